pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Central stall/flush controller for the in-order F->DE->RR->EX->WB pipeline.
// - Tracks in-flight register writes in a per-register busy-counter scoreboard.
// - Drives the stall/flush inputs of the if_de, de_rr and rr_ex pipeline registers
//   (stall = hold contents, flush = synchronous clear to 0 / valid 0).
// - Resolves RAW/WAW dependencies, memory back-pressure and EX branch redirects.
// PARAMETERS
// - NUM_REGS      8   architectural registers tracked
// - IDX_W         3   register index width, log2(NUM_REGS)
// - LAT_W         2   EX latency class width; counter width
// - FLUSH_CYCLES  2   cycles spent in DRAIN after a redirect (>=1)
// PORTS
// - clk           in   1         clock; all state updates on posedge
// - rst           in   1         synchronous reset, active-high
// - rr_valid      in   1         RR stage holds a valid instruction
// - rr_src1_idx   in   IDX_W     source 1 register index
// - rr_src1_used  in   1         source 1 is read
// - rr_src2_idx   in   IDX_W     source 2 register index
// - rr_src2_used  in   1         source 2 is read
// - rr_dst_idx    in   IDX_W     destination register index
// - rr_dst_we     in   1         instruction writes rr_dst_idx
// - rr_lat        in   LAT_W     cycles until result is readable; 0 = forwarded, no busy
// - mem_busy      in   1         EX/memory cannot advance this cycle
// - ex_redirect   in   1         EX resolved a taken/mispredicted branch
// - stall_if_de   out  1         hold if_de register
// - stall_de_rr   out  1         hold de_rr register
// - stall_rr_ex   out  1         hold rr_ex register
// - flush_if_de   out  1         clear if_de register
// - flush_de_rr   out  1         clear de_rr register
// - flush_rr_ex   out  1         clear rr_ex register (bubble insert)
// - issue         out  1         RR instruction moves into rr_ex this cycle
// - sb_busy       out  NUM_REGS  bit i = counter[i] != 0
// BEHAVIOUR
// - Reset: state RUN, DRAIN counter 0, all scoreboard counters 0.
//   While rst=1, every output is 0, including sb_busy.
// - Outputs are combinational from state, counters and inputs; zero added latency.
// - hazard = rr_valid & ((src1_used & cnt[src1]!=0) | (src2_used & cnt[src2]!=0)
//   | (dst_we & cnt[dst]!=0)). The dst term is the WAW check.
// - Priority, one case per cycle:
//   - redirect: state RUN & ex_redirect & !mem_busy.
//     flush_if_de = flush_de_rr = flush_rr_ex = 1; all stalls 0; issue 0.
//     Next state DRAIN; drain count = FLUSH_CYCLES.
//   - DRAIN: all three flushes 1, stalls 0, issue 0. Decrement the drain count;
//     go to RUN when it reaches 1.
//     ex_redirect in DRAIN is ignored: the EX stage was already flushed.
//   - mem_busy (RUN): all three stalls 1, flushes 0, issue 0; counters frozen.
//     ex_redirect is not sampled while mem_busy = 1.
//   - hazard (RUN): stall_if_de = stall_de_rr = 1, flush_rr_ex = 1, stall_rr_ex 0, issue 0.
//   - otherwise: issue = rr_valid; all stalls and flushes 0.
// - Scoreboard update each posedge, except while frozen by mem_busy:
//   - every nonzero counter decrements by 1;
//   - then, if issue & rr_dst_we & rr_lat != 0: cnt[rr_dst_idx] <= rr_lat
//     (the load overrides the decrement for that entry).
//   - Counters keep decrementing during redirect/DRAIN, because older instructions
//     in EX still complete.
//   - No saturation or wrap: a counter never decrements below 0.
// - Reset asserted mid-DRAIN or with busy counters: everything clears on the next edge.
// STRUCTURE
// - Package pipe_ctrl_pkg:
//   - state enum {ST_RUN, ST_DRAIN};
//   - IDX_W, LAT_W, NUM_REGS defaults;
//   - hazard-reason codes for debug.
// - Sub-module hazard_scoreboard: counter array, decrement/load logic, sb_busy,
//   and the three combinational lookups (src1, src2, dst busy).
// - Top level: FSM, DRAIN counter, priority mux for stall/flush/issue.
// TESTING
// - Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, sb_busy=8'h00;
//   state RUN after release.
// - RAW: issue dst=3, lat=2 at t0; next instruction has src1=3.
//   Expect stall_if_de/de_rr=1 and flush_rr_ex=1 at t1 and t2, issue=1 at t3,
//   sb_busy[3]: 1 -> 1 -> 0.
// - WAW plus lat=0: issue dst=5, lat=3, then dst=5, lat=0 -> stalled 3 cycles.
//   A lat=0 writer of reg 6 leaves sb_busy[6]=0.
// - mem_busy high for 3 cycles with cnt[2]=2 -> all stalls 1, flushes 0, issue 0;
//   cnt[2] stays 2, then decrements after release.
// - Redirect: ex_redirect pulse at t0 -> all flushes 1 at t0, t1, t2
//   (FLUSH_CYCLES=2); issue 0; stalls 0; RUN at t3.
//   Redirect coinciding with a RAW hazard -> flushes win, stalls 0.
// - Reset at t1 of DRAIN with sb_busy=8'h18 -> next cycle RUN, sb_busy=0, flushes 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the controller state encoding and the debug hazard-reason codes.
package pipe_ctrl_pkg;

  localparam int DEF_NUM_REGS     = 8;
  localparam int DEF_IDX_W        = 3;
  localparam int DEF_LAT_W        = 2;
  localparam int DEF_FLUSH_CYCLES = 2;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    HZ_NONE = 2'd0,
    HZ_SRC1 = 2'd1,
    HZ_SRC2 = 2'd2,
    HZ_WAW  = 2'd3
  } hazard_reason_e;

  // First matching dependency wins; HZ_NONE means the RR instruction is clear.
  function automatic hazard_reason_e hazard_reason(input logic src1_hit,
                                                   input logic src2_hit,
                                                   input logic dst_hit);
    hazard_reason_e r;
    if (src1_hit) begin
      r = HZ_SRC1;
    end else if (src2_hit) begin
      r = HZ_SRC2;
    end else if (dst_hit) begin
      r = HZ_WAW;
    end else begin
      r = HZ_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register busy-counter scoreboard tracking cycles until each in-flight
// register write becomes readable, with combinational busy lookups.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int LAT_W    = DEF_LAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update_en,
  input  logic                load_en,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic [LAT_W-1:0]    load_val,
  input  logic [IDX_W-1:0]    src1_idx,
  input  logic [IDX_W-1:0]    src2_idx,
  input  logic [IDX_W-1:0]    dst_idx,
  output logic                src1_busy,
  output logic                src2_busy,
  output logic                dst_busy,
  output logic [NUM_REGS-1:0] busy
);

  logic [LAT_W-1:0]    cnt_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;

  // Counter update: decrement toward zero, a new issue load overrides its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (update_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (load_en && (load_idx == IDX_W'(i))) begin
          cnt_r[i] <= load_val;
        end else if (cnt_r[i] != '0) begin
          cnt_r[i] <= cnt_r[i] - LAT_W'(1);
        end
      end
    end
  end

  // Busy flag per register.
  always_comb begin
    busy_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_s[i] = (cnt_r[i] != '0);
    end
  end

  assign busy      = busy_s;
  assign src1_busy = busy_s[src1_idx];
  assign src2_busy = busy_s[src2_idx];
  assign dst_busy  = busy_s[dst_idx];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: redirect drain FSM, memory back-pressure,
// RAW/WAW interlock and issue control for the if_de, de_rr and rr_ex registers.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int LAT_W        = DEF_LAT_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rr_valid,
  input  logic [IDX_W-1:0]    rr_src1_idx,
  input  logic                rr_src1_used,
  input  logic [IDX_W-1:0]    rr_src2_idx,
  input  logic                rr_src2_used,
  input  logic [IDX_W-1:0]    rr_dst_idx,
  input  logic                rr_dst_we,
  input  logic [LAT_W-1:0]    rr_lat,
  input  logic                mem_busy,
  input  logic                ex_redirect,
  output logic                stall_if_de,
  output logic                stall_de_rr,
  output logic                stall_rr_ex,
  output logic                flush_if_de,
  output logic                flush_de_rr,
  output logic                flush_rr_ex,
  output logic                issue,
  output logic [NUM_REGS-1:0] sb_busy
);

  localparam int DRAIN_W = $clog2(FLUSH_CYCLES + 1);

  ctrl_state_e         state_r, next_state_s;
  logic [DRAIN_W-1:0]  drain_cnt_r, drain_next_s;
  logic                src1_busy_s, src2_busy_s, dst_busy_s;
  logic [NUM_REGS-1:0] busy_s;
  hazard_reason_e      reason_s;
  logic                hazard_s;
  logic                freeze_s;
  logic                stall_fe_s, stall_rr_s, flush_fe_s, flush_rr_s, issue_s;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .LAT_W    (LAT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .update_en (~freeze_s),
    .load_en   (issue_s & rr_dst_we & (rr_lat != '0)),
    .load_idx  (rr_dst_idx),
    .load_val  (rr_lat),
    .src1_idx  (rr_src1_idx),
    .src2_idx  (rr_src2_idx),
    .dst_idx   (rr_dst_idx),
    .src1_busy (src1_busy_s),
    .src2_busy (src2_busy_s),
    .dst_busy  (dst_busy_s),
    .busy      (busy_s)
  );

  assign reason_s = hazard_reason(rr_src1_used & src1_busy_s,
                                  rr_src2_used & src2_busy_s,
                                  rr_dst_we & dst_busy_s);
  assign hazard_s = rr_valid & (reason_s != HZ_NONE);

  // Controller state and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= '0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= drain_next_s;
    end
  end

  // Priority: redirect, drain, memory back-pressure, hazard bubble, issue.
  always_comb begin
    next_state_s = state_r;
    drain_next_s = drain_cnt_r;
    freeze_s     = 1'b0;
    stall_fe_s   = 1'b0;
    stall_rr_s   = 1'b0;
    flush_fe_s   = 1'b0;
    flush_rr_s   = 1'b0;
    issue_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ex_redirect && !mem_busy) begin
          flush_fe_s   = 1'b1;
          flush_rr_s   = 1'b1;
          next_state_s = ST_DRAIN;
          drain_next_s = DRAIN_W'(FLUSH_CYCLES);
        end else if (mem_busy) begin
          stall_fe_s = 1'b1;
          stall_rr_s = 1'b1;
          freeze_s   = 1'b1;
        end else if (hazard_s) begin
          stall_fe_s = 1'b1;
          flush_rr_s = 1'b1;
        end else begin
          issue_s = rr_valid;
        end
      end
      ST_DRAIN: begin
        flush_fe_s = 1'b1;
        flush_rr_s = 1'b1;
        if (drain_cnt_r <= DRAIN_W'(1)) begin
          next_state_s = ST_RUN;
          drain_next_s = '0;
        end else begin
          drain_next_s = drain_cnt_r - DRAIN_W'(1);
        end
      end
      default: begin
        next_state_s = ST_RUN;
        drain_next_s = '0;
      end
    endcase
  end

  // Everything reads as idle while reset is held.
  assign stall_if_de = stall_fe_s & ~rst;
  assign stall_de_rr = stall_fe_s & ~rst;
  assign stall_rr_ex = stall_rr_s & ~rst;
  assign flush_if_de = flush_fe_s & ~rst;
  assign flush_de_rr = flush_fe_s & ~rst;
  assign flush_rr_ex = flush_rr_s & ~rst;
  assign issue       = issue_s & ~rst;
  assign sb_busy     = busy_s & {NUM_REGS{~rst}};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios with hand-derived expectations plus
// randomized traffic checked against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic       clk;
  logic       rst;
  logic       rr_valid;
  logic [2:0] rr_src1_idx;
  logic       rr_src1_used;
  logic [2:0] rr_src2_idx;
  logic       rr_src2_used;
  logic [2:0] rr_dst_idx;
  logic       rr_dst_we;
  logic [1:0] rr_lat;
  logic       mem_busy;
  logic       ex_redirect;
  logic       stall_if_de, stall_de_rr, stall_rr_ex;
  logic       flush_if_de, flush_de_rr, flush_rr_ex;
  logic       issue;
  logic [7:0] sb_busy;
  logic [14:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: remaining busy cycles per register, and remaining drain cycles.
  int cnt_m [8];
  bit drain_m;
  int drain_left_m;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .rr_valid     (rr_valid),
    .rr_src1_idx  (rr_src1_idx),
    .rr_src1_used (rr_src1_used),
    .rr_src2_idx  (rr_src2_idx),
    .rr_src2_used (rr_src2_used),
    .rr_dst_idx   (rr_dst_idx),
    .rr_dst_we    (rr_dst_we),
    .rr_lat       (rr_lat),
    .mem_busy     (mem_busy),
    .ex_redirect  (ex_redirect),
    .stall_if_de  (stall_if_de),
    .stall_de_rr  (stall_de_rr),
    .stall_rr_ex  (stall_rr_ex),
    .flush_if_de  (flush_if_de),
    .flush_de_rr  (flush_de_rr),
    .flush_rr_ex  (flush_rr_ex),
    .issue        (issue),
    .sb_busy      (sb_busy)
  );

  assign obs = {stall_if_de, stall_de_rr, stall_rr_ex,
                flush_if_de, flush_de_rr, flush_rr_ex, issue, sb_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs this cycle, straight from the priority rules.
  function automatic logic [14:0] model_exp();
    logic [7:0] b;
    logic       haz;
    for (int i = 0; i < 8; i++) b[i] = (cnt_m[i] > 0);
    if (rst) return 15'h0000;
    if (drain_m || (ex_redirect && !mem_busy)) return {7'b0001110, b};
    if (mem_busy) return {7'b1110000, b};
    haz = rr_valid && ((rr_src1_used && cnt_m[rr_src1_idx] > 0) ||
                       (rr_src2_used && cnt_m[rr_src2_idx] > 0) ||
                       (rr_dst_we && cnt_m[rr_dst_idx] > 0));
    if (haz) return {7'b1100010, b};
    return {6'b000000, rr_valid, b};
  endfunction

  task automatic model_advance();
    logic [14:0] e;
    e = model_exp();
    if (rst) begin
      for (int i = 0; i < 8; i++) cnt_m[i] = 0;
      drain_m = 1'b0;
      drain_left_m = 0;
    end else begin
      if (!(mem_busy && !drain_m)) begin
        for (int i = 0; i < 8; i++) if (cnt_m[i] > 0) cnt_m[i] = cnt_m[i] - 1;
        if (e[8] && rr_dst_we && rr_lat != 2'd0) cnt_m[rr_dst_idx] = int'(rr_lat);
      end
      if (drain_m) begin
        drain_left_m = drain_left_m - 1;
        if (drain_left_m == 0) drain_m = 1'b0;
      end else if (ex_redirect && !mem_busy) begin
        drain_m = 1'b1;
        drain_left_m = FLUSH_CYCLES;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_rr(input logic v, input logic [2:0] s1, input logic s1u,
                        input logic [2:0] s2, input logic s2u,
                        input logic [2:0] d, input logic we, input logic [1:0] lat);
    rr_valid = v; rr_src1_idx = s1; rr_src1_used = s1u;
    rr_src2_idx = s2; rr_src2_used = s2u;
    rr_dst_idx = d; rr_dst_we = we; rr_lat = lat;
  endtask

  task automatic set_idle();
    rst = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
    set_rr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0);
  endtask

  task automatic settle_idle();
    set_idle();
    repeat (4) tick();
  endtask

  task automatic rand_inputs();
    set_rr(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom_range(0, 3)));
    rr_valid    = ($urandom_range(0, 3) != 0);
    mem_busy    = drain_m ? 1'b0 : ($urandom_range(0, 7) == 0);
    ex_redirect = ($urandom_range(0, 15) == 0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rand_inputs();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs !== 15'h0000) begin
        n_bad++; $display("FAIL reset_hold%0d got %h want %h", c, obs, 15'h0000);
      end
      tick();
    end
    set_idle();
    #1;
    n_cmp++;
    if (obs !== 15'h0000) begin
      n_bad++; $display("FAIL reset_idle got %h want %h", obs, 15'h0000);
    end
    tick();
    set_rr(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd7, 1'b0, 2'd0);
    #1;
    n_cmp++;
    if (obs !== 15'h0100) begin
      n_bad++; $display("FAIL reset_run_issue got %h want %h", obs, 15'h0100);
    end
    tick();
  endtask

  task automatic test_raw();
    logic [14:0] exp_t [4] = '{15'h0100, 15'h6208, 15'h6208, 15'h0100};
    settle_idle();
    for (int t = 0; t < 4; t++) begin
      if (t == 0) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 2'd2);
      else        set_rr(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 2'd0);
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL raw_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      tick();
    end
  endtask

  task automatic test_waw();
    logic [14:0] exp_t [7] = '{15'h0100, 15'h6220, 15'h6220, 15'h6220,
                               15'h0100, 15'h0100, 15'h0000};
    settle_idle();
    for (int t = 0; t < 7; t++) begin
      if (t == 0)      set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 2'd3);
      else if (t < 5)  set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 2'd0);
      else if (t == 5) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 2'd0);
      else             set_idle();
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL waw_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      tick();
    end
  endtask

  task automatic test_mem_busy();
    logic [14:0] exp_t [7] = '{15'h0100, 15'h7004, 15'h7004, 15'h7004,
                               15'h0004, 15'h0004, 15'h0000};
    settle_idle();
    for (int t = 0; t < 7; t++) begin
      set_idle();
      if (t == 0) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 2'd2);
      if (t >= 1 && t <= 3) begin
        mem_busy = 1'b1;
        set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 2'd1);
      end
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL mem_busy_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [14:0] exp_t [4] = '{15'h0E00, 15'h0E00, 15'h0E00, 15'h0100};
    settle_idle();
    for (int t = 0; t < 4; t++) begin
      set_idle();
      set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 2'd0);
      ex_redirect = (t == 0 || t == 2);
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL redirect_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      tick();
    end
  endtask

  task automatic test_redirect_hazard();
    logic [14:0] exp_t [5] = '{15'h0100, 15'h0E10, 15'h0E10, 15'h0E10, 15'h0100};
    settle_idle();
    for (int t = 0; t < 5; t++) begin
      set_idle();
      if (t == 0) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 2'd3);
      else        set_rr(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0);
      ex_redirect = (t == 1);
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL redir_haz_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_drain();
    logic [14:0] exp_t [4] = '{15'h0100, 15'h0108, 15'h0E18, 15'h0E18};
    settle_idle();
    for (int t = 0; t < 4; t++) begin
      set_idle();
      if (t == 0) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 2'd3);
      if (t == 1) set_rr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 2'd3);
      ex_redirect = (t == 2);
      #1;
      n_cmp++;
      if (obs !== exp_t[t]) begin
        n_bad++; $display("FAIL rst_drain_t%0d got %h want %h", t, obs, exp_t[t]);
      end
      if (t < 3) tick();
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 15'h0000) begin
      n_bad++; $display("FAIL rst_drain_hold got %h want %h", obs, 15'h0000);
    end
    tick();
    set_idle();
    #1;
    n_cmp++;
    if (obs !== 15'h0000) begin
      n_bad++; $display("FAIL rst_drain_after got %h want %h", obs, 15'h0000);
    end
    tick();
    set_rr(1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 2'd0);
    #1;
    n_cmp++;
    if (obs !== 15'h0100) begin
      n_bad++; $display("FAIL rst_drain_run got %h want %h", obs, 15'h0100);
    end
    tick();
  endtask

  task automatic test_random();
    logic [14:0] e;
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 49) == 0);
      #1;
      e = model_exp();
      n_cmp++;
      if (obs !== e) begin
        n_bad++; $display("FAIL random_c%0d got %h want %h", c, obs, e);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    drain_m = 1'b0;
    drain_left_m = 0;
    set_idle();
    rst = 1'b1;
    test_reset();
    test_raw();
    test_waw();
    test_mem_busy();
    test_redirect();
    test_redirect_hazard();
    test_reset_in_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
